// File: rtl/prio_grant_arbiter_pkg.sv
// Shared types and helpers for the registered priority / round-robin grant arbiter.
package prio_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Callers slice the result down to their own N (N is at most 32).
  function automatic logic [31:0] idx_to_onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/prio_grant_arbiter_if.sv
// Request/grant bundle between request sources, the arbiter and the grant consumer.
interface prio_grant_arbiter_if #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
);
  logic [N-1:0]    req;
  logic            gnt_valid;
  logic            gnt_ready;
  logic [IDXW-1:0] gnt_idx;
  logic [N-1:0]    gnt_onehot;
  logic            any_req;

  modport master (
    input  req, gnt_ready,
    output gnt_valid, gnt_idx, gnt_onehot, any_req
  );

  modport slave (
    output req, gnt_ready,
    input  gnt_valid, gnt_idx, gnt_onehot, any_req
  );
endinterface

// File: rtl/prio_grant_arbiter_pick.sv
// Combinational circular find-first-set: first set bit of req at or after base, wrapping at N-1.
module prio_pick #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] base,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [IDXW-1:0] off;
  logic [IDXW:0]   sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[base +: N];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDXW'(i);
    end
    // Un-rotate with an explicit mod-N wrap so non-power-of-two N works.
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IDXW+1)'(N)) idx = IDXW'(sum - (IDXW+1)'(N));
    else                     idx = IDXW'(sum);
  end

  assign found = |req;

endmodule

// File: rtl/prio_grant_arbiter.sv
// Registered N-way grant arbiter, fixed priority or round-robin, with valid/ready grant handshake.
// state | meaning
// IDLE  | no grant held, gnt_valid low
// GRANT | grant presented, held stable until gnt_valid && gnt_ready
module prio_grant_arbiter
  import prio_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int RR   = MODE_FIXED,
  parameter int IDXW = $clog2(N)
) (
  input logic                  clk,
  input logic                  rst_n,
  prio_grant_arbiter_if.master bus
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic [N-1:0]    onehot_q, onehot_d;

  logic [IDXW-1:0] ptr_inc;
  logic [IDXW-1:0] base;
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;

  assign ptr_inc = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + IDXW'(1);

  // A back-to-back grant must search from the pointer this handshake is about to set.
  always_comb begin
    base = '0;
    if (RR == MODE_RR) begin
      base = (state_q == GRANT) ? ptr_inc : ptr_q;
    end
  end

  prio_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .base  (base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    onehot_d = onehot_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d    = pick_idx;
          onehot_d = N'(idx_to_onehot(5'(pick_idx)));
          valid_d  = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (bus.gnt_ready) begin
          if (RR == MODE_RR) ptr_d = ptr_inc;
          if (pick_found) begin
            idx_d    = pick_idx;
            onehot_d = N'(idx_to_onehot(5'(pick_idx)));
          end else begin
            valid_d  = 1'b0;
            onehot_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
    end
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.any_req    = |bus.req;

endmodule

// File: doc/prio_grant_arbiter.md
# prio_grant_arbiter

Parametrised, registered successor to the team's 4-input priority encoder. It takes N request lines and issues one grant at a time as an index plus a one-hot vector. Two modes are supported: fixed priority (lowest index wins) and round-robin. Each grant is held on a valid/ready handshake until the consumer accepts it. The block sits between request sources (DMA channels, bus masters) and a shared resource that takes one owner per handshake.

## Interface
Parameters:
- N, 4, number of request lines; legal range 2..32.
- RR, 0, mode select: 0 = fixed priority (index 0 highest), 1 = round-robin.
- IDXW, $clog2(N), width of the grant index. Derived; never overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request lines, level-sensitive; bit i = requester i.
- gnt_valid  out  1  a grant is being presented.
- gnt_ready  in  1  consumer accepts the presented grant this cycle.
- gnt_idx  out  IDXW  index of the granted requester.
- gnt_onehot  out  N  one-hot form of gnt_idx; all zero when gnt_valid = 0.
- any_req  out  1  combinational OR of req (the reference encoder's "valid" function).

## Operation
- States: IDLE (no grant held) and GRANT (grant presented, waiting for handshake).
- IDLE, req != 0 at the edge: register the winner into gnt_idx/gnt_onehot, set gnt_valid, go to GRANT.
- IDLE, req == 0: stay in IDLE with outputs unchanged.
- GRANT: gnt_idx, gnt_onehot and gnt_valid hold stable until gnt_valid && gnt_ready.
  - A grant is sticky. Deasserting the granted req bit, or asserting a higher-priority bit, does not change or withdraw it.
- Handshake (gnt_valid && gnt_ready at the edge):
  - req != 0 in that cycle: load the next winner in the same edge and stay in GRANT. This gives back-to-back grants, one per cycle.
  - req == 0 in that cycle: clear gnt_valid and gnt_onehot, go to IDLE. gnt_idx keeps its last value.
- Winner selection, fixed mode (RR=0): lowest set index of req.
- Winner selection, round-robin mode (RR=1):
  - Scan starts at pointer ptr, ascending, wrapping from N-1 to 0.
  - The winner is the first set bit found.
- Pointer update:
  - On each handshake, ptr ← (accepted idx + 1) mod N. Wrap is explicit, so N need not be a power of two.
  - For a back-to-back grant, the next winner is computed from this updated ptr.
  - ptr is unused in fixed mode and stays 0.
- Reset values:
  - gnt_valid = 0, gnt_idx = 0, gnt_onehot = 0, ptr = 0, state = IDLE.
  - Asserting rst_n mid-grant drops gnt_valid immediately, without waiting for a clock. The in-flight grant is lost; no handshake is implied.
- Bits of req above N-1 do not exist. Width rules: IDXW bits for gnt_idx and ptr; the mod-N increment compares against N-1, not 2^IDXW-1.

## Timing
- Request-to-grant latency is 1 cycle. req sampled at edge k while IDLE gives gnt_valid = 1 after edge k.
- Sustained throughput is 1 grant per cycle with gnt_ready tied high and req nonzero.
- gnt_ready high while gnt_valid = 0 is ignored.
- any_req is purely combinational, with zero latency.
- All other outputs are registered, with no combinational path from req or gnt_ready.

## Structure
- Package prio_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - mode constants MODE_FIXED = 0 and MODE_RR = 1;
  - a function returning the one-hot vector for an index.
- Sub-module prio_pick: combinational, parameter N. Inputs are req and base; outputs are found and idx.
  - Implements the rotate, find-first-set and un-rotate search.
  - Fixed mode instantiates it with base = 0.
- Top level holds the FSM, the ptr register and the output registers.

## Test plan
- Reset:
  - Hold rst_n low with req = 4'b1111: gnt_valid = 0, gnt_idx = 0, gnt_onehot = 0.
  - Release with req = 0: stays IDLE for 5 cycles.
- Fixed mode, N=4, req = 4'b1010:
  - gnt_idx = 1, gnt_onehot = 4'b0010 one cycle later.
  - Hold gnt_ready low for 3 cycles while req changes to 4'b0001: grant stays idx 1.
  - Pulse ready: next cycle gnt_idx = 0.
- RR mode, N=4, req = 4'b1111 held, gnt_ready = 1: grant sequence 0, 1, 2, 3, 0, one per cycle.
- RR skip:
  - After accepting idx 1 (ptr = 2), set req = 4'b0011: next grant idx 0, ptr becomes 1.
  - Then req = 4'b0011 again: next grant idx 1.
- N=5 wrap:
  - req = 5'b10000: idx 4, onehot 5'b10000.
  - Accept in RR mode, ptr = 0; then req = 5'b10001: grant idx 0.
- Reset mid-grant:
  - Drop rst_n asynchronously, between edges, while gnt_valid = 1 and gnt_ready = 0: gnt_valid falls before the next edge.
  - After release with req = 4'b0100: grant idx 2 one cycle later, ptr restarted at 0.
